// File: rtl/rectifier_step_sequencer_pkg.sv
// Shared constants and FSM encoding for the rectifier control-step sequencer.
// Holds the default timebase/timeout values next to the control-system constants.
package rectifier_step_sequencer_pkg;

   localparam logic [31:0] DEF_PERIOD_CYCLES  = 32'd2000;
   localparam logic [15:0] DEF_TIMEOUT_CYCLES = 16'd1000;
   localparam int          DEF_OVR_W          = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_TICK,
      ST_MEAS,
      ST_WAIT_MEAS,
      ST_CTRL,
      ST_WAIT_CTRL,
      ST_COMMIT,
      ST_FAULT
   } step_state_t;

   // States in which a period tick means the previous step has not finished.
   function automatic logic in_step(input step_state_t s);
      return (s == ST_MEAS) || (s == ST_WAIT_MEAS) || (s == ST_CTRL) ||
             (s == ST_WAIT_CTRL) || (s == ST_COMMIT);
   endfunction

endpackage

// File: rtl/rectifier_step_sequencer_step_period_tick.sv
// Control-period timebase: counts 0..PERIOD_CYCLES-1, tick in the last count (combinational from count).
// No backpressure; enable low or clr holds the count at 0 with no tick.
module step_period_tick
   import rectifier_step_sequencer_pkg::*;
#(
   parameter logic [31:0] PERIOD_CYCLES = DEF_PERIOD_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic clr,
   output logic tick
);

   logic [31:0] cnt;
   logic        last;

   assign last = (cnt == PERIOD_CYCLES - 32'd1);
   assign tick = enable && !clr && last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr || !enable || last) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 32'd1;
      end
   end

endmodule

// File: rtl/rectifier_step_sequencer.sv
// Per-period scheduler: start pulses in dependency order, PI commit, overrun/hang detection.
// Latency tick->sta_meas, done->next start/commit: 1 cycle; a stage holds the chain until its done pulse.
module rectifier_step_sequencer
   import rectifier_step_sequencer_pkg::*;
#(
   parameter logic [31:0] PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
   parameter logic [15:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int          OVR_W          = DEF_OVR_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             rst_user,
   input  logic             meas_done,
   input  logic             ctrl_done,
   output logic             sta_meas,
   output logic             sta_theta,
   output logic             sta_ctrl,
   output logic             commit,
   output logic             busy,
   output logic             fault,
   output logic             overrun,
   output logic [OVR_W-1:0] overrun_cnt,
   output logic [15:0]      step_cnt
);

   localparam logic [OVR_W-1:0] OVR_ONE = {{(OVR_W-1){1'b0}}, 1'b1};

   step_state_t state;
   logic [15:0] to_cnt;
   logic [15:0] to_nxt;
   logic        to_hit;
   logic        tick;

   step_period_tick #(
      .PERIOD_CYCLES (PERIOD_CYCLES)
   ) u_tick (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .clr    (rst_user),
      .tick   (tick)
   );

   // Limit is judged on the post-increment value, so exactly TIMEOUT_CYCLES wait cycles are allowed.
   assign to_nxt = to_cnt + 16'd1;
   assign to_hit = (to_nxt == TIMEOUT_CYCLES);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         to_cnt      <= '0;
         sta_meas    <= 1'b0;
         sta_theta   <= 1'b0;
         sta_ctrl    <= 1'b0;
         commit      <= 1'b0;
         busy        <= 1'b0;
         fault       <= 1'b0;
         overrun     <= 1'b0;
         overrun_cnt <= '0;
         step_cnt    <= '0;
      end else if (rst_user) begin
         state       <= ST_IDLE;
         to_cnt      <= '0;
         sta_meas    <= 1'b0;
         sta_theta   <= 1'b0;
         sta_ctrl    <= 1'b0;
         commit      <= 1'b0;
         busy        <= 1'b0;
         fault       <= 1'b0;
         overrun     <= 1'b0;
         overrun_cnt <= '0;
         step_cnt    <= '0;
      end else begin
         sta_meas  <= 1'b0;
         sta_theta <= 1'b0;
         sta_ctrl  <= 1'b0;
         commit    <= 1'b0;

         // A tick during a step is dropped; the next step waits for the following tick.
         if (tick && in_step(state)) begin
            overrun <= 1'b1;
            if (overrun_cnt != '1) overrun_cnt <= overrun_cnt + OVR_ONE;
         end

         case (state)
            ST_IDLE: begin
               if (enable) state <= ST_WAIT_TICK;
            end
            ST_WAIT_TICK: begin
               if (!enable) begin
                  state <= ST_IDLE;
               end else if (tick) begin
                  state     <= ST_MEAS;
                  sta_meas  <= 1'b1;
                  sta_theta <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            ST_MEAS: begin
               state  <= ST_WAIT_MEAS;
               to_cnt <= '0;
            end
            ST_WAIT_MEAS: begin
               if (meas_done) begin
                  state    <= ST_CTRL;
                  sta_ctrl <= 1'b1;
               end else if (to_hit) begin
                  state <= ST_FAULT;
                  fault <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  to_cnt <= to_nxt;
               end
            end
            ST_CTRL: begin
               state  <= ST_WAIT_CTRL;
               to_cnt <= '0;
            end
            ST_WAIT_CTRL: begin
               if (ctrl_done) begin
                  state    <= ST_COMMIT;
                  commit   <= 1'b1;
                  step_cnt <= step_cnt + 16'd1;
               end else if (to_hit) begin
                  state <= ST_FAULT;
                  fault <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  to_cnt <= to_nxt;
               end
            end
            ST_COMMIT: begin
               busy  <= 1'b0;
               state <= enable ? ST_WAIT_TICK : ST_IDLE;
            end
            ST_FAULT: begin
               state <= ST_FAULT;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rectifier_step_sequencer.sv
// Directed bench: two sequencer instances (timeout 8 and 40, period 20) with done-pulse responders.
module tb_rectifier_step_sequencer;

   localparam int A_SM = 0, A_SC = 1, A_CM = 2, A_FAULT = 3, B_SM = 4, B_SC = 5, B_CM = 6;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic a_en = 0, a_rstu = 0, a_md = 0, a_cd = 0, a_spur = 0;
   logic a_sm, a_st, a_sc, a_cm, a_busy, a_fault, a_ovr;
   logic [7:0]  a_ovc;
   logic [15:0] a_step;
   logic b_en = 0, b_rstu = 0, b_md = 0, b_cd = 0;
   logic b_sm, b_st, b_sc, b_cm, b_busy, b_fault, b_ovr;
   logic [7:0]  b_ovc;
   logic [15:0] b_step;

   rectifier_step_sequencer #(.PERIOD_CYCLES(32'd20), .TIMEOUT_CYCLES(16'd8), .OVR_W(8)) dut_a (
      .clk(clk), .rst(rst), .enable(a_en), .rst_user(a_rstu),
      .meas_done(a_md), .ctrl_done(a_cd | a_spur),
      .sta_meas(a_sm), .sta_theta(a_st), .sta_ctrl(a_sc), .commit(a_cm),
      .busy(a_busy), .fault(a_fault), .overrun(a_ovr), .overrun_cnt(a_ovc), .step_cnt(a_step)
   );

   rectifier_step_sequencer #(.PERIOD_CYCLES(32'd20), .TIMEOUT_CYCLES(16'd40), .OVR_W(8)) dut_b (
      .clk(clk), .rst(rst), .enable(b_en), .rst_user(b_rstu),
      .meas_done(b_md), .ctrl_done(b_cd),
      .sta_meas(b_sm), .sta_theta(b_st), .sta_ctrl(b_sc), .commit(b_cm),
      .busy(b_busy), .fault(b_fault), .overrun(b_ovr), .overrun_cnt(b_ovc), .step_cnt(b_step)
   );

   // Responders: a done pulse N cycles after the matching start; a delay <= 0 withholds it.
   int a_mdly = 3, a_cdly = 5, a_mc = -1, a_cc = -1;
   int b_mdly = 1, b_cdly = 25, b_mc = -1, b_cc = -1;

   initial forever begin
      @(posedge clk); #1;
      a_md = 0; a_cd = 0;
      if (a_mc > 0) begin a_mc--; if (a_mc == 0) begin a_md = 1; a_mc = -1; end end
      if (a_cc > 0) begin a_cc--; if (a_cc == 0) begin a_cd = 1; a_cc = -1; end end
      if (a_sm && a_mdly > 0) a_mc = a_mdly;
      if (a_sc && a_cdly > 0) a_cc = a_cdly;
   end

   initial forever begin
      @(posedge clk); #1;
      b_md = 0; b_cd = 0;
      if (b_mc > 0) begin b_mc--; if (b_mc == 0) begin b_md = 1; b_mc = -1; end end
      if (b_cc > 0) begin b_cc--; if (b_cc == 0) begin b_cd = 1; b_cc = -1; end end
      if (b_sm && b_mdly > 0) b_mc = b_mdly;
      if (b_sc && b_cdly > 0) b_cc = b_cdly;
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic logic pick(input int sel);
      case (sel)
         A_SM:    pick = a_sm;
         A_SC:    pick = a_sc;
         A_CM:    pick = a_cm;
         A_FAULT: pick = a_fault;
         B_SM:    pick = b_sm;
         B_SC:    pick = b_sc;
         B_CM:    pick = b_cm;
         default: pick = 1'b0;
      endcase
   endfunction

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Returns the cycle a signal is first seen high, or -1 when the budget runs out.
   task automatic wait_sig(input int sel, input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (pick(sel)) begin at = cyc; break; end
      end
   endtask

   int c0, r, t_sm, t_sc, t_cm, t_f, t2, t, np;

   initial begin
      step(3);
      chk("rst_outs_a", {a_sm, a_st, a_sc, a_cm, a_busy, a_fault, a_ovr, a_ovc, a_step}, 0);
      chk("rst_outs_b", {b_sm, b_st, b_sc, b_cm, b_busy, b_fault, b_ovr, b_ovc, b_step}, 0);
      @(negedge clk) rst = 1'b1;
      step(2);

      // Nominal step: tick at 19, starts at 20, meas 3 cycles, ctrl 5 cycles.
      a_en = 1; c0 = cyc;
      wait_sig(A_SM, 40, t_sm);  chk("t1_sm_lat", t_sm - c0, 20);
      chk("t1_theta", a_st, 1);
      wait_sig(A_SC, 20, t_sc);  chk("t1_sc_lat", t_sc - t_sm, 4);
      chk("t1_busy", a_busy, 1);
      wait_sig(A_CM, 20, t_cm);  chk("t1_cm_lat", t_cm - t_sc, 6);
      chk("t1_step", a_step, 1);
      step(1);
      chk("t1_busy_off", a_busy, 0);
      chk("t1_cm_pulse", a_cm, 0);

      // Withheld ctrl_done: fault 9 cycles after sta_ctrl, sticky, silent.
      a_cdly = -1;
      wait_sig(A_SM, 30, t2);    chk("t2_period", t2 - t_sm, 20);
      wait_sig(A_SC, 20, t_sc);
      wait_sig(A_FAULT, 20, t_f); chk("t2_fault_lat", t_f - t_sc, 9);
      np = 0;
      repeat (45) begin step(1); np += int'(a_sm) + int'(a_sc) + int'(a_cm); end
      chk("t2_no_pulses", np, 0);
      chk("t2_fault_sticky", a_fault, 1);
      a_rstu = 1; r = cyc; step(1); a_rstu = 0;
      chk("t2_fault_clr", a_fault, 0);
      chk("t2_step_clr", a_step, 0);

      // Restart after clear; meas_done lands exactly on the timeout limit.
      a_cdly = 5; a_mdly = 8;
      wait_sig(A_SM, 40, t_sm);  chk("t2_restart", t_sm - r, 21);
      wait_sig(A_SC, 20, t_sc);  chk("t3_sc_at_limit", t_sc - t_sm, 9);
      chk("t3_no_fault", a_fault, 0);
      wait_sig(A_CM, 20, t_cm);  chk("t3_cm_lat", t_cm - t_sc, 6);

      // Spurious ctrl_done while waiting for the tick.
      step(2);
      a_spur = 1; np = 0; step(1); a_spur = 0;
      repeat (5) begin np += int'(a_cm); step(1); end
      chk("t4_spur_commit", np, 0);
      chk("t4_step", a_step, 1);
      a_en = 0;

      // Overrun: ctrl 25 cycles spans the next tick.
      b_en = 1; c0 = cyc;
      wait_sig(B_SM, 40, t_sm);  chk("t5_sm_lat", t_sm - c0, 20);
      wait_sig(B_CM, 60, t_cm);  chk("t5_cm_lat", t_cm - t_sm, 28);
      chk("t5_ovr", b_ovr, 1);
      chk("t5_ovc", b_ovc, 1);
      b_cdly = 39;
      wait_sig(B_SM, 40, t2);    chk("t5_next_sm", t2 - t_sm, 40);

      // 150 steps each spanning two ticks: 300 more overruns, counter saturates.
      for (int k = 0; k < 150; k++) wait_sig(B_CM, 80, t);
      chk("t6_ovc_sat", b_ovc, 255);
      chk("t6_steps", b_step, 151);
      chk("t6_no_fault", b_fault, 0);

      // Async reset in the middle of WAIT_CTRL.
      a_cdly = -1; a_en = 1;
      wait_sig(A_SC, 80, t_sc);
      step(3);
      chk("t7_busy_pre", a_busy, 1);
      #3 rst = 1'b0;
      #1;
      chk("t7_rst_a", {a_sm, a_st, a_sc, a_cm, a_busy, a_fault, a_ovr, a_ovc, a_step}, 0);
      chk("t7_rst_b", {b_sm, b_st, b_sc, b_cm, b_busy, b_fault, b_ovr, b_ovc, b_step}, 0);
      step(2);
      chk("t7_rst_hold", {a_sm, a_sc, a_cm, a_busy, a_fault, a_step}, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
